// File: rtl/div_pkg.sv
// Shared definitions for the divider and its downstream result stages:
// result entry layout {dbz, q, r} and the quotient fill used for divide-by-zero.
package div_pkg;

  // Remainder occupies the least significant field of an entry.
  localparam int unsigned ENTRY_R_LSB = 0;

  // Quotient field written for a divide-by-zero result is all ones.
  localparam logic DBZ_Q_FILL_BIT = 1'b1;

  // Total entry width: dbz flag + quotient + remainder.
  function automatic int unsigned div_entry_w(input int unsigned width);
    return 2 * width + 1;
  endfunction

  // Quotient field sits directly above the remainder.
  function automatic int unsigned entry_q_lsb(input int unsigned width);
    return width;
  endfunction

  // The dbz flag is the entry MSB.
  function automatic int unsigned entry_dbz_bit(input int unsigned width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/div_result_buffer_sync_fifo.sv
// Circular show-ahead FIFO. Pointers carry one extra wrap bit so that full and
// empty are distinguishable; the low bits index the storage array.
module sync_fifo #(
  parameter int DW    = 9,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DW-1:0]              wr_data,
  input  logic                       rd_en,
  output logic [DW-1:0]              rd_data,
  output logic                       rd_valid,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [DW-1:0] mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic          empty_s;
  logic          full_s;
  logic          do_rd_s;
  logic          do_wr_s;

  assign empty_s  = (wr_ptr_r == rd_ptr_r);
  assign full_s   = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign do_rd_s  = rd_en & ~empty_s;
  assign do_wr_s  = wr_en & (~full_s | do_rd_s);

  assign rd_data  = mem_r[rd_ptr_r[AW-1:0]];
  assign rd_valid = ~empty_s;
  assign full     = full_s;
  assign count    = wr_ptr_r - rd_ptr_r;

  // Storage array: cleared on reset so a discarded entry never reappears on the head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DW{1'b0}};
      end
    end else if (do_wr_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end else begin
      mem_r <= mem_r;
    end
  end

  // Read/write pointers advance independently, wrapping through the extra bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
    end else begin
      wr_ptr_r <= do_wr_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
      rd_ptr_r <= do_rd_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
    end
  end

endmodule

// File: rtl/div_result_buffer.sv
// Result buffer behind the iterative divider. Reserves a slot per accepted
// request (credit_ok gates the divider's in_valid), turns divide-by-zero
// rejections into explicit entries, and flags protocol violations in err.
module div_result_buffer
  import div_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       div_accept,
  input  logic                       div_out_valid,
  input  logic [WIDTH-1:0]           div_q,
  input  logic [WIDTH-1:0]           div_r,
  input  logic                       div_dbz,
  output logic                       credit_ok,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_q,
  output logic [WIDTH-1:0]           out_r,
  output logic                       out_dbz,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err
);

  localparam int CW      = $clog2(DEPTH) + 1;
  localparam int EW      = int'(div_entry_w(WIDTH));
  localparam int Q_LSB   = int'(entry_q_lsb(WIDTH));
  localparam int DBZ_BIT = int'(entry_dbz_bit(WIDTH));
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [CW-1:0] resv_r;
  logic          err_r;
  logic          pop_s;
  logic          wr_req_s;
  logic          collision_s;
  logic          overflow_s;
  logic          fifo_wr_s;
  logic          full_s;
  logic [EW-1:0] wr_data_s;
  logic [EW-1:0] head_s;

  assign pop_s       = out_valid & out_ready;
  assign wr_req_s    = div_out_valid | div_dbz;
  assign collision_s = div_out_valid & div_dbz;
  assign overflow_s  = wr_req_s & full_s & ~pop_s;
  assign fifo_wr_s   = wr_req_s & ~overflow_s;

  // credit_ok depends only on the reservation count (no path from out_ready).
  assign credit_ok = ~rst & (resv_r < DEPTH_C);
  assign err       = err_r;
  assign out_dbz   = head_s[DBZ_BIT];
  assign out_q     = head_s[Q_LSB +: WIDTH];
  assign out_r     = head_s[ENTRY_R_LSB +: WIDTH];

  // Entry formation: a real divider result wins over a dbz rejection in the same cycle.
  always_comb begin
    wr_data_s = {EW{1'b0}};
    if (div_out_valid) begin
      wr_data_s[DBZ_BIT]               = 1'b0;
      wr_data_s[Q_LSB +: WIDTH]        = div_q;
      wr_data_s[ENTRY_R_LSB +: WIDTH]  = div_r;
    end else begin
      wr_data_s[DBZ_BIT]               = 1'b1;
      wr_data_s[Q_LSB +: WIDTH]        = {WIDTH{DBZ_Q_FILL_BIT}};
      wr_data_s[ENTRY_R_LSB +: WIDTH]  = {WIDTH{1'b0}};
    end
  end

  // Reservation counter: +1 per accepted request, -1 per pop, results reuse their slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resv_r <= {CW{1'b0}};
    end else begin
      case ({div_accept, pop_s})
        2'b10:   resv_r <= (resv_r != DEPTH_C) ? (resv_r + ONE_C) : resv_r;
        2'b01:   resv_r <= (resv_r != {CW{1'b0}}) ? (resv_r - ONE_C) : resv_r;
        default: resv_r <= resv_r;
      endcase
    end
  end

  // Sticky protocol error: dbz/result collision or a write into a full buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | collision_s | overflow_s;
    end
  end

  sync_fifo #(
    .DW    (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (fifo_wr_s),
    .wr_data  (wr_data_s),
    .rd_en    (pop_s),
    .rd_data  (head_s),
    .rd_valid (out_valid),
    .full     (full_s),
    .count    (count)
  );

endmodule

// File: tb/tb_div_result_buffer.sv
// Bench for div_result_buffer: plays the divider upstream and a random consumer
// downstream; expected entries are queued at issue time and compared on every pop.
module tb_div_result_buffer;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             div_accept = 1'b0;
  logic             div_out_valid = 1'b0;
  logic [WIDTH-1:0] div_q = '0;
  logic [WIDTH-1:0] div_r = '0;
  logic             div_dbz = 1'b0;
  logic             credit_ok;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_r;
  logic             out_dbz;
  logic [$clog2(DEPTH):0] count;
  logic             err;

  div_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .div_accept(div_accept), .div_out_valid(div_out_valid),
    .div_q(div_q), .div_r(div_r), .div_dbz(div_dbz), .credit_ok(credit_ok),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_r(out_r),
    .out_dbz(out_dbz), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: issued-not-popped entries in order, divider results pending.
  logic [2*WIDTH:0]   exp_q[$];
  logic [2*WIDTH-1:0] pend_q[$];
  int n_issued  = 0;
  int n_written = 0;
  int n_popped  = 0;
  bit model_on  = 1'b0;
  bit busy      = 1'b0;
  int lat_cnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every handshake pops the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", {out_dbz, out_q, out_r}, 32'hFFFF);
      end else begin
        check("head_entry", {out_dbz, out_q, out_r}, exp_q.pop_front());
      end
      n_popped++;
    end
  end

  task automatic step();
    int exp_cnt;
    @(posedge clk);
    #1;
    div_accept    = 1'b0;
    div_out_valid = 1'b0;
    div_dbz       = 1'b0;
    if (model_on && !rst) begin
      exp_cnt = n_written - n_popped;
      check("count", count, exp_cnt);
      check("credit_ok", credit_ok, ((n_issued - n_popped) < DEPTH) ? 1 : 0);
      check("out_valid", out_valid, (exp_cnt > 0) ? 1 : 0);
    end
  endtask

  task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    div_accept = 1'b1;
    n_issued++;
    if (y == 0) begin
      div_dbz = 1'b1;
      exp_q.push_back({1'b1, {WIDTH{1'b1}}, {WIDTH{1'b0}}});
      n_written++;
    end else begin
      exp_q.push_back({1'b0, x / y, x % y});
      pend_q.push_back({x / y, x % y});
    end
  endtask

  task automatic deliver();
    {div_q, div_r} = pend_q.pop_front();
    div_out_valid  = 1'b1;
    n_written++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    out_ready = 1'b0;
    #1;
    check("rst_count", count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_q", out_q, 0);
    check("rst_out_r", out_r, 0);
    check("rst_out_dbz", out_dbz, 0);
    check("rst_err", err, 0);
    check("rst_credit_ok", credit_ok, 0);
    exp_q.delete();
    pend_q.delete();
    n_issued = 0; n_written = 0; n_popped = 0;
    busy = 1'b0;
    step();
    step();
    rst = 1'b0;
    model_on = 1'b1;
    #1;
    check("credit_after_release", credit_ok, 1);
  endtask

  initial begin
    int accepts;
    int guard;
    logic [WIDTH-1:0] rx, ry;

    // Power-on reset.
    step();
    do_reset();

    // 13 / 3 with the consumer stalled: head appears one cycle after the pulse and holds.
    step();
    issue(4'd13, 4'd3);
    step();
    step();
    check("no_early_valid", out_valid, 0);
    deliver();
    #1;
    check("no_bypass", out_valid, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      check("hold_q", out_q, 4);
      check("hold_r", out_r, 1);
      check("hold_dbz", out_dbz, 0);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Divide by zero: entry formed in the accept cycle, no reservation left behind.
    issue(4'd7, 4'd0);
    #1;
    check("dbz_no_bypass", out_valid, 0);
    step();
    check("dbz_flag", out_dbz, 1);
    check("dbz_q", out_q, 4'hF);
    check("dbz_r", out_r, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();

    // Fill with the consumer stalled until credit runs out.
    accepts = 0;
    while (credit_ok && accepts < 8) begin
      issue(4'($urandom_range(0, 15)), 4'($urandom_range(1, 15)));
      accepts++;
      step();
      deliver();
      step();
    end
    check("fill_accepts", accepts, DEPTH);
    check("fill_count", count, DEPTH);
    check("fill_err", err, 0);
    check("fill_credit", credit_ok, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("credit_back", credit_ok, 1);
    issue(4'd9, 4'd4);
    step();
    deliver();
    step();

    // Write into a full buffer without a pop is dropped and flagged.
    model_on = 1'b0;
    div_out_valid = 1'b1; div_q = 4'd2; div_r = 4'd1;
    step();
    check("ovf_err", err, 1);
    check("ovf_count", count, DEPTH);
    // Write into a full buffer alongside a pop succeeds.
    out_ready = 1'b1;
    div_out_valid = 1'b1; div_q = 4'd9; div_r = 4'd2;
    exp_q.push_back({1'b0, 4'd9, 4'd2});
    step();
    check("full_pop_count", count, DEPTH);
    for (int i = 0; i < DEPTH; i++) step();
    out_ready = 1'b0;
    check("drain_count", count, 0);
    check("drain_queue", exp_q.size(), 0);
    check("ovf_err_sticky", err, 1);
    do_reset();

    // Result and dbz together: only the result is stored, err sticks.
    step();
    model_on = 1'b0;
    div_accept = 1'b1; div_dbz = 1'b1; div_out_valid = 1'b1; div_q = 4'd5; div_r = 4'd3;
    exp_q.push_back({1'b0, 4'd5, 4'd3});
    step();
    check("coll_err", err, 1);
    check("coll_count", count, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("coll_drained", count, 0);
    for (int i = 0; i < 3; i++) step();
    check("coll_err_sticky", err, 1);
    do_reset();

    // Reset with three stored and one in flight.
    step();
    for (int i = 0; i < 3; i++) begin
      issue(4'($urandom_range(0, 15)), 4'($urandom_range(1, 15)));
      step();
      deliver();
      step();
    end
    issue(4'd6, 4'd5);
    step();
    check("mid_count", count, 3);
    do_reset();

    // Randomised traffic.
    for (int c = 0; c < 10000; c++) begin
      step();
      if (busy) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          deliver();
          busy = 1'b0;
        end
      end else if (credit_ok && $urandom_range(0, 3) != 0) begin
        rx = 4'($urandom_range(0, 15));
        ry = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        issue(rx, ry);
        if (ry != 0) begin
          busy = 1'b1;
          lat_cnt = $urandom_range(1, 4);
        end
      end
      out_ready = ($urandom_range(0, 2) != 0);
    end

    // Drain, bounded.
    guard = 0;
    while ((exp_q.size() != 0 || busy) && guard < 200) begin
      step();
      if (busy) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          deliver();
          busy = 1'b0;
        end
      end
      out_ready = 1'b1;
      guard++;
    end
    check("drain_timeout", (guard < 200) ? 1 : 0, 1);
    step();
    out_ready = 1'b0;
    check("final_queue", exp_q.size(), 0);
    check("final_err", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
